// File: rtl/uart1_rx_sync2.sv
// Two-flop synchronizer for an asynchronous level input; resets to 1 so an
// idle-high line does not look active while reset releases.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= 1'b1;
            sync_r <= 1'b1;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/uart1_rx.sv
// 8N1 serial receiver: mid-bit sampling of a synchronized rx line, parallel
// byte output and a level interrupt that holds until the CPU clears it.
module uart1_rx #(
    parameter int CLOCK_DIV          = 8,
    parameter int CLOCK_COUNTER_BITS = 4
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       interrupt,
    input  logic       interrupt_clear
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

    localparam logic [CLOCK_COUNTER_BITS-1:0] CNT_ZERO = CLOCK_COUNTER_BITS'(0);
    localparam logic [CLOCK_COUNTER_BITS-1:0] CNT_ONE  = CLOCK_COUNTER_BITS'(1);
    localparam logic [CLOCK_COUNTER_BITS-1:0] CNT_HALF = CLOCK_COUNTER_BITS'(CLOCK_DIV / 2 - 1);
    localparam logic [CLOCK_COUNTER_BITS-1:0] CNT_FULL = CLOCK_COUNTER_BITS'(CLOCK_DIV - 1);

    logic                          rxs_s;
    logic                          tick_s;
    state_t                        state_r, state_s;
    logic [CLOCK_COUNTER_BITS-1:0] cnt_r, cnt_s;
    logic [2:0]                    bit_r, bit_s;
    logic [7:0]                    shift_r, shift_s;
    logic [7:0]                    data_r, data_s;
    logic                          irq_r, irq_s;

    sync2 u_sync2 (
        .clk   (clk),
        .rst_n (nreset),
        .d     (rx),
        .q     (rxs_s)
    );

    assign tick_s = (cnt_r == CNT_ZERO);

    // Next-state, bit timing, shift register and output register updates.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        bit_s   = bit_r;
        shift_s = shift_r;
        data_s  = data_r;
        if (interrupt_clear) begin
            irq_s = 1'b0;
        end else begin
            irq_s = irq_r;
        end

        case (state_r)
            ST_IDLE: begin
                if (!rxs_s) begin
                    // Counter expires CLOCK_DIV/2 edges from now: mid start bit.
                    state_s = ST_START;
                    cnt_s   = CNT_HALF;
                    bit_s   = 3'd0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (tick_s) begin
                    if (rxs_s) begin
                        state_s = ST_IDLE;
                        cnt_s   = CNT_ZERO;
                    end else begin
                        state_s = ST_DATA;
                        cnt_s   = CNT_FULL;
                    end
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            ST_DATA: begin
                if (tick_s) begin
                    shift_s = {rxs_s, shift_r[7:1]};
                    cnt_s   = CNT_FULL;
                    if (bit_r == 3'd7) begin
                        state_s = ST_STOP;
                    end else begin
                        bit_s = bit_r + 3'd1;
                    end
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            ST_STOP: begin
                if (tick_s) begin
                    cnt_s = CNT_ZERO;
                    bit_s = 3'd0;
                    if (rxs_s) begin
                        // Good stop bit: set wins over a simultaneous clear.
                        data_s  = shift_r;
                        irq_s   = 1'b1;
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_BREAK;
                    end
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            ST_BREAK: begin
                if (rxs_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_BREAK;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = CNT_ZERO;
                bit_s   = 3'd0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            bit_r   <= 3'd0;
            shift_r <= 8'h00;
            data_r  <= 8'h00;
            irq_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            bit_r   <= bit_s;
            shift_r <= shift_s;
            data_r  <= data_s;
            irq_r   <= irq_s;
        end
    end

    assign data      = data_r;
    assign interrupt = irq_r;

endmodule

// File: tb/tb_uart1_rx.sv
// Directed bench for uart1_rx at CLOCK_DIV=8: framing, glitch and break
// rejection, back-to-back frames, clear/set priority and mid-frame reset.
module tb_uart1_rx;

    logic       clk;
    logic       nreset;
    logic       rx;
    logic [7:0] data;
    logic       interrupt;
    logic       interrupt_clear;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int start_cyc = 0;
    int rise_cyc = 0;
    logic irq_prev = 1'b0;

    uart1_rx #(
        .CLOCK_DIV          (8),
        .CLOCK_COUNTER_BITS (4)
    ) dut (
        .clk             (clk),
        .nreset          (nreset),
        .rx              (rx),
        .data            (data),
        .interrupt       (interrupt),
        .interrupt_clear (interrupt_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record the cycle index at which interrupt is first seen high.
    always @(negedge clk) begin
        if (interrupt && !irq_prev) rise_cyc = cyc;
        irq_prev = interrupt;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; drives one 8N1 frame, 8 clk per bit.
    task automatic send_byte(input logic [7:0] b, input logic stop_val, input int stop_len);
        start_cyc = cyc;
        rx = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (8) @(negedge clk);
        end
        rx = stop_val;
        repeat (stop_len) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic pulse_clear();
        interrupt_clear = 1'b1;
        @(negedge clk);
        interrupt_clear = 1'b0;
    endtask

    initial begin
        nreset = 1'b0;
        rx = 1'b1;
        interrupt_clear = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_data", {24'h0, data}, 32'h0);
        check_eq("reset_irq", {31'h0, interrupt}, 32'h0);
        nreset = 1'b1;
        repeat (5) @(negedge clk);

        // 1: first frame and interrupt latency
        send_byte(8'h5A, 1'b1, 8);
        check_eq("t1_data", {24'h0, data}, 32'h5A);
        check_eq("t1_irq", {31'h0, interrupt}, 32'h1);
        check_eq("t1_latency", rise_cyc - start_cyc, 32'd79);
        repeat (20) @(negedge clk);
        check_eq("t1_irq_hold", {31'h0, interrupt}, 32'h1);

        // 2: two-cycle clear
        interrupt_clear = 1'b1;
        @(negedge clk);
        check_eq("t2_irq_cleared", {31'h0, interrupt}, 32'h0);
        @(negedge clk);
        interrupt_clear = 1'b0;
        @(negedge clk);
        check_eq("t2_irq_low", {31'h0, interrupt}, 32'h0);
        check_eq("t2_data", {24'h0, data}, 32'h5A);

        // 3: start-bit glitch rejected, then a clean frame
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        check_eq("t3_glitch_irq", {31'h0, interrupt}, 32'h0);
        check_eq("t3_glitch_data", {24'h0, data}, 32'h5A);
        send_byte(8'hA5, 1'b1, 8);
        check_eq("t3_data", {24'h0, data}, 32'hA5);
        check_eq("t3_irq", {31'h0, interrupt}, 32'h1);
        pulse_clear();

        // 4: framing error with held-low stop, then recovery
        send_byte(8'h3C, 1'b0, 16);
        repeat (10) @(negedge clk);
        check_eq("t4_ferr_irq", {31'h0, interrupt}, 32'h0);
        check_eq("t4_ferr_data", {24'h0, data}, 32'hA5);
        send_byte(8'h81, 1'b1, 8);
        check_eq("t4_data", {24'h0, data}, 32'h81);
        check_eq("t4_irq", {31'h0, interrupt}, 32'h1);

        // 5: back-to-back frames with overrun, no clear
        send_byte(8'h00, 1'b1, 8);
        check_eq("t5_first_data", {24'h0, data}, 32'h00);
        send_byte(8'hFF, 1'b1, 8);
        check_eq("t5_second_data", {24'h0, data}, 32'hFF);
        check_eq("t5_irq", {31'h0, interrupt}, 32'h1);
        pulse_clear();
        repeat (4) @(negedge clk);
        check_eq("t5_irq_cleared", {31'h0, interrupt}, 32'h0);

        // 5b: clear asserted exactly on the completion edge
        fork
            send_byte(8'h66, 1'b1, 8);
            begin
                repeat (78) @(negedge clk);
                interrupt_clear = 1'b1;
                @(negedge clk);
                interrupt_clear = 1'b0;
            end
        join
        check_eq("t5_set_wins_irq", {31'h0, interrupt}, 32'h1);
        check_eq("t5_set_wins_data", {24'h0, data}, 32'h66);

        // 6: reset in the middle of a data bit
        fork
            send_byte(8'hC3, 1'b1, 8);
            begin
                repeat (36) @(negedge clk);
                nreset = 1'b0;
                #1;
                check_eq("t6_rst_data", {24'h0, data}, 32'h0);
                check_eq("t6_rst_irq", {31'h0, interrupt}, 32'h0);
            end
        join
        rx = 1'b1;
        repeat (2) @(negedge clk);
        nreset = 1'b1;
        repeat (10) @(negedge clk);
        check_eq("t6_idle_irq", {31'h0, interrupt}, 32'h0);
        send_byte(8'h5A, 1'b1, 8);
        check_eq("t6_data", {24'h0, data}, 32'h5A);
        check_eq("t6_irq", {31'h0, interrupt}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
